// File: rtl/wb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_pkg : shared widths, zero-register index and FSM state type for wb_regfile
// Rev 1.0
// ---------------------------------------------------------------------------
package wb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 7;
  localparam int REG_COUNT  = 2 ** DEF_ADDR_W;

  localparam logic [DEF_ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } wb_state_t;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_clear_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_clear_seq : post-reset sweep that zeroes every register, then signals Ready
// Rev 1.0
// ---------------------------------------------------------------------------
module wb_clear_seq
  import wb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_idx,
  output logic              ready
);

  wb_state_t         state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= CLEAR;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    clr_we    = 1'b0;
    ready     = 1'b0;
    case (state)
      CLEAR: begin
        clr_we  = 1'b1;
        idx_nxt = idx + ADDR_W'(1);
        // Last entry written this cycle; the wrapped index is unused in RUN
        if (&idx) state_nxt = RUN;
      end
      RUN: begin
        ready = 1'b1;
      end
      default: begin
        state_nxt = CLEAR;
      end
    endcase
  end

  assign clr_idx = idx;

endmodule : wb_clear_seq
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_regfile : writeback stage + 2-read architectural register file.
// Optional macro WB_BYPASS_EN forwards the same-cycle WB write to the read ports.
// Rev 1.0
// ---------------------------------------------------------------------------
module wb_regfile
  import wb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WBEnable,
  input  logic [DATA_W-1:0] ResultAlu,
  input  logic [ADDR_W-1:0] WBAddress,
  input  logic [ADDR_W-1:0] ReadAddrA,
  input  logic [ADDR_W-1:0] ReadAddrB,
  output logic [DATA_W-1:0] ReadDataA,
  output logic [DATA_W-1:0] ReadDataB,
  output logic              Ready,
  output logic [31:0]       RetireCount
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic              clr_we;
  logic [ADDR_W-1:0] clr_idx;
  logic              ready;
  logic              user_we;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              byp_a, byp_b;
  logic [31:0]       retire_cnt;

  // No reset on the array: the sweep provides the cleared state
  logic [DATA_W-1:0] mem [DEPTH];

  wb_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk     (clk),
    .rst     (rst),
    .clr_we  (clr_we),
    .clr_idx (clr_idx),
    .ready   (ready)
  );

  assign user_we  = ready && WBEnable && (WBAddress != ZERO_ADDR);
  assign mem_we   = clr_we || user_we;
  assign mem_addr = clr_we ? clr_idx : WBAddress;
  assign mem_data = clr_we ? '0 : ResultAlu;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire_cnt <= '0;
    end else if (ready && WBEnable) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end

`ifdef WB_BYPASS_EN
  assign byp_a = user_we && (ReadAddrA == WBAddress);
  assign byp_b = user_we && (ReadAddrB == WBAddress);
`else
  assign byp_a = 1'b0;
  assign byp_b = 1'b0;
`endif

  always_comb begin
    ReadDataA = mem[ReadAddrA];
    if (!ready || ReadAddrA == ZERO_ADDR) ReadDataA = '0;
    else if (byp_a)                       ReadDataA = ResultAlu;
  end

  always_comb begin
    ReadDataB = mem[ReadAddrB];
    if (!ready || ReadAddrB == ZERO_ADDR) ReadDataB = '0;
    else if (byp_b)                       ReadDataB = ResultAlu;
  end

  assign Ready       = ready;
  assign RetireCount = retire_cnt;

endmodule : wb_regfile
`default_nettype wire
